shake_length_tracker: RTL



---
 rtl/shake_pkg.sv | 29 ++
 rtl/shake_word_pos.sv | 47 ++++
 rtl/shake_length_tracker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shake_pkg.sv
// Shared types and helpers for the SHAKE message-length tracker.
package shake_pkg;

  // SHAKE variant selected at load time
  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } shake_mode_t;

  // Rate expressed in W-bit words (1344/64 and 1088/64)
  localparam int unsigned RATE128_WORDS = 21;
  localparam int unsigned RATE256_WORDS = 17;

  // Width of the in-block word index (holds 0..20)
  localparam int unsigned IDX_W = 5;

  // Tracker control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } trk_state_t;

  // Number of words per rate block for the given mode
  function automatic logic [IDX_W-1:0] rate_words(input shake_mode_t mode);
    return (mode == SHAKE256) ? IDX_W'(RATE256_WORDS) : IDX_W'(RATE128_WORDS);
  endfunction

endpackage

// File: rtl/shake_word_pos.sv
// Word position inside the current rate block and completed-block counter.
module shake_word_pos
  import shake_pkg::*;
#(
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_accept,
  input  logic [IDX_W-1:0]     i_rate,
  output logic [IDX_W-1:0]     o_word_idx,
  output logic [BLK_CNT_W-1:0] o_blk_cnt,
  output logic                 o_block_end_c
);

  logic [IDX_W-1:0]     r_word_idx;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic                 w_at_end;

  assign w_at_end      = (r_word_idx == (i_rate - IDX_W'(1)));
  assign o_block_end_c = i_accept && w_at_end;
  assign o_word_idx    = r_word_idx;
  assign o_blk_cnt     = r_blk_cnt;

  // Advance the index per accepted word; wrap at the block end and bump the saturating block count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx <= '0;
      r_blk_cnt  <= '0;
    end else if (i_clear || i_load) begin
      r_word_idx <= '0;
      r_blk_cnt  <= '0;
    end else if (i_accept) begin
      if (w_at_end) begin
        r_word_idx <= '0;
        if (r_blk_cnt != {BLK_CNT_W{1'b1}}) begin
          r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
        end
      end else begin
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/shake_length_tracker.sv
// SHAKE message-length tracker: counts a loaded bit length down one word per
// accepted transfer and reports word/block position for absorb and padding.
// Optional byte_mask output is enabled with SHAKE_TRACK_BYTEMASK_EN.
module shake_length_tracker
  import shake_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned W         = 64,
  parameter  int unsigned BLK_CNT_W = 16,
  localparam int unsigned VB_W      = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_len_in,
  input  logic                 i_mode,
  input  logic                 i_clear,
  input  logic                 i_word_valid,
  output logic                 o_word_ready,
  output logic [WIDTH-1:0]     o_remaining,
  output logic [VB_W-1:0]      o_valid_bits,
  output logic [IDX_W-1:0]     o_word_idx,
  output logic [BLK_CNT_W-1:0] o_blk_cnt,
  output logic                 o_last_word,
  output logic                 o_last_block,
  output logic                 o_block_end,
`ifdef SHAKE_TRACK_BYTEMASK_EN
  output logic [W/8-1:0]       o_byte_mask,
`endif
  output logic                 o_done
);

  trk_state_t       r_state;
  trk_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_remaining;
  logic [IDX_W-1:0] r_rate;
  logic             w_accept;
  logic             w_in_count;
  logic             w_fits_word;
  logic [IDX_W-1:0] w_words_left;
  logic [WIDTH-1:0] w_rest_bits;
  logic             w_block_end_c;

  assign w_in_count   = (r_state == ST_COUNT);
  assign o_word_ready = w_in_count;
  assign w_accept     = i_word_valid && w_in_count;
  assign w_fits_word  = (r_remaining <= WIDTH'(W));
  assign w_words_left = r_rate - o_word_idx;
  assign w_rest_bits  = WIDTH'(w_words_left) * WIDTH'(W);
  assign o_remaining  = r_remaining;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear beats load beats the final accept
  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (i_load) begin
      w_state_nxt = ST_COUNT;
    end else if (w_accept && w_fits_word) begin
      w_state_nxt = ST_DONE;
    end
  end

  // Remaining-bit counter and rate latch; subtraction saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_rate      <= IDX_W'(RATE128_WORDS);
    end else if (i_clear) begin
      r_remaining <= '0;
      r_rate      <= IDX_W'(RATE128_WORDS);
    end else if (i_load) begin
      r_remaining <= i_len_in;
      r_rate      <= rate_words(shake_mode_t'(i_mode));
    end else if (w_accept) begin
      r_remaining <= (r_remaining < WIDTH'(W)) ? '0 : (r_remaining - WIDTH'(W));
    end
  end

  shake_word_pos #(
    .BLK_CNT_W (BLK_CNT_W)
  ) u_word_pos (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (i_clear),
    .i_load        (i_load),
    .i_accept      (w_accept && !i_clear && !i_load),
    .i_rate        (r_rate),
    .o_word_idx    (o_word_idx),
    .o_blk_cnt     (o_blk_cnt),
    .o_block_end_c (w_block_end_c)
  );

  // Status outputs, forced low outside COUNT except done
  always_comb begin
    o_valid_bits = '0;
    o_last_word  = 1'b0;
    o_last_block = 1'b0;
    o_block_end  = 1'b0;
    o_done       = (r_state == ST_DONE);
    if (w_in_count) begin
      o_valid_bits = (r_remaining < WIDTH'(W)) ? VB_W'(r_remaining) : VB_W'(W);
      o_last_word  = w_fits_word;
      o_last_block = (r_remaining <= w_rest_bits);
      o_block_end  = w_block_end_c;
    end
  end

`ifdef SHAKE_TRACK_BYTEMASK_EN
  logic [VB_W:0] w_nbytes;

  assign w_nbytes = ((VB_W+1)'(o_valid_bits) + (VB_W+1)'(7)) >> 3;

  // One bit per byte lane that carries message bits
  always_comb begin
    o_byte_mask = '0;
    for (int i = 0; i < int'(W / 8); i++) begin
      o_byte_mask[i] = ((VB_W+1)'(i) < w_nbytes);
    end
  end
`endif

endmodule
